div_issue: RTL and testbench
============================

# div_issue

Operand-preparation and result-fixup stage wrapped around the pipelined unsigned divider in the M-extension path of the CPU. It accepts RISC-V DIV/DIVU/REM/REMU ops from execute and converts signed operands to magnitudes. It issues one op per cycle to the divider and tracks in-flight ops in a metadata FIFO. On divider output it applies sign correction and the divide-by-zero/overflow overrides, then returns the architectural result with its destination tag.

## Interface
- LATENCY, 28: divider pipeline depth in cycles while not stalled.
- DEPTH, 32: metadata FIFO entries; must be ≥ LATENCY + 2.
- clk  in  1  clock; everything samples on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- stall  in  1  global pipeline stall; freezes this block and the divider.
- op_valid  in  1  execute presents an op.
- op_ready  out  1  `!stall && fifo_count < DEPTH`; accept = op_valid && op_ready.
- op_func  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
- op_a  in  32  dividend (rs1).
- op_b  in  32  divisor (rs2).
- op_tag  in  5  destination register index.
- div_dividend, div_divisor  out  32  unsigned magnitudes to the divider.
- div_in_valid  out  1  issue strobe to the divider.
- div_ctrl  out  2  equals op_func; bit 1 selects remainder inside the divider.
- div_ans  in  32  divider result, quotient or remainder per ctrl.
- div_out_valid  in  1  divider result valid.
- res_valid  out  1  result valid, one cycle per op.
- res_data  out  32  architectural result.
- res_tag  out  5  destination tag of res_data.

## Operation
- Issue register, loaded on accept:
  - Signed ops: magnitude = x[31] ? -x : x; 0x80000000 passes as 0x80000000.
  - Unsigned ops: operands pass unchanged.
  - div_in_valid = 1 for exactly one cycle per accepted op. It holds 0 when nothing is accepted while !stall, and holds its value while stall is high.
- Every op, including special cases, is issued to the divider so that results stay in order.
- Metadata pushed at accept: neg (1b), spec (1b), spec_val (32b), tag (5b).
  - DIV: neg = a[31]^b[31].
  - REM: neg = a[31].
  - Unsigned ops: neg = 0.
  - Divide by zero (b == 0): spec = 1. spec_val = 0xFFFFFFFF for DIV/DIVU; spec_val = op_a for REM/REMU.
  - Signed overflow (DIV/REM with a = 0x80000000, b = 0xFFFFFFFF): spec = 1. spec_val = 0x80000000 for DIV; 0 for REM.
- Pop happens when div_out_valid && !stall && FIFO not empty.
  - Result = spec ? spec_val : (neg ? -div_ans : div_ans).
  - Result and tag are registered into res_data/res_tag, and res_valid is set for that cycle.
- div_out_valid with an empty FIFO is dropped and res_valid stays 0. This covers stale divider contents after a reset.
- Push and pop in the same cycle leave fifo_count unchanged. Pointers wrap modulo DEPTH.
- fifo_count counts ops from accept until pop.

## Timing
- No stall: accept in cycle N, div_in_valid in N+1, div_out_valid in N+1+LATENCY, res_valid in N+2+LATENCY (LATENCY+2 = 30 cycles).
- Throughput: one op per cycle.
- stall high: no accept, no push, no pop. All registers hold, including res_valid/res_data. Latency stretches by the number of stall cycles.
- res_valid is a single-cycle pulse per op while !stall.
- rst asserted, asynchronously: all outputs 0, FIFO pointers/count 0, op_ready follows stall. Ops in flight at reset are lost.

## Test plan
- DIV a=0xFFFFFFF9 (-7), b=2 → res_data=0xFFFFFFFD; REM with the same operands → 0xFFFFFFFF. Both appear 30 cycles after accept, with tags preserved.
- DIVU a=0xFFFFFFFF, b=1 → 0xFFFFFFFF; REMU a=7, b=0 → 7; DIV a=5, b=0 → 0xFFFFFFFF.
- DIV a=0x80000000, b=0xFFFFFFFF → 0x80000000; REM with the same operands → 0.
- Issue 32 back-to-back ops with res side not stalled → all accepted, res_valid on 32 consecutive cycles in order, fifo_count ends at 0.
- Set DEPTH = LATENCY + 2, then hold stall high while the pipe is full → op_ready=0 throughout; results keep order after release.
- Raise stall for 5 cycles mid-flight → the result is delayed by exactly 5 cycles and res_valid is held, not duplicated. Assert rst mid-flight → outputs 0 immediately and no res_valid for pre-reset ops.

Source files
------------

// File: rtl/div_issue.sv
// div_issue: operand preparation and result fixup around a pipelined unsigned
// divider for RISC-V DIV/DIVU/REM/REMU. Signed operands are reduced to
// magnitudes before issue. Per-op metadata travels through an in-order FIFO,
// and sign correction plus the divide-by-zero/overflow overrides are applied
// when the divider hands its answer back.
module div_issue #(
   parameter int unsigned LATENCY = 28,
   parameter int unsigned DEPTH   = 32
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_stall,
   input  logic        i_op_valid,
   output logic        o_op_ready,
   input  logic [1:0]  i_op_func,
   input  logic [31:0] i_op_a,
   input  logic [31:0] i_op_b,
   input  logic [4:0]  i_op_tag,
   output logic [31:0] o_div_dividend,
   output logic [31:0] o_div_divisor,
   output logic        o_div_in_valid,
   output logic [1:0]  o_div_ctrl,
   input  logic [31:0] i_div_ans,
   input  logic        i_div_out_valid,
   output logic        o_res_valid,
   output logic [31:0] o_res_data,
   output logic [4:0]  o_res_tag
);

   localparam int unsigned PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
   localparam logic [31:0] INT_MIN = 32'h8000_0000;
   localparam logic [31:0] ALL_ONE = 32'hFFFF_FFFF;

   // Every op issued to the divider must still have a metadata slot when its
   // answer returns, so the FIFO has to cover the full pipe plus the
   // issue and result registers.
   if (DEPTH < LATENCY + 2) begin : g_depth_check
      $error("div_issue: DEPTH must be at least LATENCY + 2");
   end

   typedef struct packed {
      logic        neg;
      logic        spec;
      logic [31:0] spec_val;
      logic [4:0]  tag;
   } meta_t;

   logic              w_accept;
   logic              w_push;
   logic              w_pop;
   logic              w_signed;
   logic              w_rem;
   logic              w_b_zero;
   logic              w_ovf;
   logic [31:0]       w_mag_a;
   logic [31:0]       w_mag_b;
   logic [31:0]       w_ans_fix;
   logic [31:0]       w_result;
   meta_t             w_meta_in;
   meta_t             w_meta_out;

   logic [31:0]       r_div_dividend;
   logic [31:0]       r_div_divisor;
   logic              r_div_in_valid;
   logic [1:0]        r_div_ctrl;
   logic              r_res_valid;
   logic [31:0]       r_res_data;
   logic [4:0]        r_res_tag;
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [CNT_W-1:0]  r_count;
   meta_t             r_mem [DEPTH];

   assign o_op_ready = !i_stall && (r_count < CNT_W'(DEPTH));
   assign w_accept   = i_op_valid && o_op_ready;
   assign w_push     = w_accept;
   assign w_pop      = i_div_out_valid && !i_stall && (r_count != '0);

   // Operand decode: sign handling, special-case detection, metadata build.
   always_comb begin
      w_signed = ~i_op_func[0];
      w_rem    = i_op_func[1];
      w_b_zero = (i_op_b == 32'd0);
      w_ovf    = w_signed && (i_op_a == INT_MIN) && (i_op_b == ALL_ONE);
      w_mag_a  = (w_signed && i_op_a[31]) ? -i_op_a : i_op_a;
      w_mag_b  = (w_signed && i_op_b[31]) ? -i_op_b : i_op_b;

      w_meta_in          = '0;
      w_meta_in.tag      = i_op_tag;
      w_meta_in.spec     = w_b_zero || w_ovf;
      if (w_signed) begin
         w_meta_in.neg = w_rem ? i_op_a[31] : (i_op_a[31] ^ i_op_b[31]);
      end
      if (w_b_zero) begin
         w_meta_in.spec_val = w_rem ? i_op_a : ALL_ONE;
      end else if (w_ovf) begin
         w_meta_in.spec_val = w_rem ? 32'd0 : INT_MIN;
      end
   end

   // Result fixup for the entry at the head of the FIFO.
   always_comb begin
      w_meta_out = r_mem[r_rd_ptr];
      w_ans_fix  = w_meta_out.neg ? -i_div_ans : i_div_ans;
      w_result   = w_meta_out.spec ? w_meta_out.spec_val : w_ans_fix;
   end

   // Issue register toward the divider; one strobe per accepted op.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_div_dividend <= '0;
         r_div_divisor  <= '0;
         r_div_in_valid <= 1'b0;
         r_div_ctrl     <= '0;
      end else if (!i_stall) begin
         r_div_in_valid <= w_accept;
         if (w_accept) begin
            r_div_dividend <= w_mag_a;
            r_div_divisor  <= w_mag_b;
            r_div_ctrl     <= i_op_func;
         end
      end
   end

   // Metadata storage; contents are only meaningful between push and pop.
   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= w_meta_in;
      end
   end

   // FIFO pointers and occupancy, wrapping modulo DEPTH.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
         end
         r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      end
   end

   // Result register; holds everything, including the valid pulse, under stall.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_res_valid <= 1'b0;
         r_res_data  <= '0;
         r_res_tag   <= '0;
      end else if (!i_stall) begin
         r_res_valid <= w_pop;
         if (w_pop) begin
            r_res_data <= w_result;
            r_res_tag  <= w_meta_out.tag;
         end
      end
   end

   assign o_div_dividend = r_div_dividend;
   assign o_div_divisor  = r_div_divisor;
   assign o_div_in_valid = r_div_in_valid;
   assign o_div_ctrl     = r_div_ctrl;
   assign o_res_valid    = r_res_valid;
   assign o_res_data     = r_res_data;
   assign o_res_tag      = r_res_tag;

endmodule

// File: tb/tb_div_issue.sv
// Bench for div_issue: behavioural pipelined divider plus directed scenarios.
module tb_div_issue;

   localparam int unsigned LATENCY = 28;
   localparam int unsigned DEPTH   = LATENCY + 2;
   // Edges from the accepting edge to the edge that raises res_valid.
   localparam int RES_LAT = LATENCY + 1;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        op_valid;
   logic        op_ready;
   logic [1:0]  op_func;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic [4:0]  op_tag;
   logic [31:0] div_dividend;
   logic [31:0] div_divisor;
   logic        div_in_valid;
   logic [1:0]  div_ctrl;
   logic [31:0] div_ans;
   logic        div_out_valid;
   logic        res_valid;
   logic [31:0] res_data;
   logic [4:0]  res_tag;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   logic [31:0] mon_d [$];
   logic [4:0]  mon_t [$];
   int          mon_c [$];
   int          acc_c [$];

   div_issue #(.LATENCY(LATENCY), .DEPTH(DEPTH)) dut (
      .i_clk           (clk),
      .i_rst           (rst),
      .i_stall         (stall),
      .i_op_valid      (op_valid),
      .o_op_ready      (op_ready),
      .i_op_func       (op_func),
      .i_op_a          (op_a),
      .i_op_b          (op_b),
      .i_op_tag        (op_tag),
      .o_div_dividend  (div_dividend),
      .o_div_divisor   (div_divisor),
      .o_div_in_valid  (div_in_valid),
      .o_div_ctrl      (div_ctrl),
      .i_div_ans       (div_ans),
      .i_div_out_valid (div_out_valid),
      .o_res_valid     (res_valid),
      .o_res_data      (res_data),
      .o_res_tag       (res_tag)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Unsigned divider model: frozen by stall, not cleared by rst.
   logic        model_clr;
   logic        pv [LATENCY];
   logic [31:0] pa [LATENCY];

   function automatic logic [31:0] udiv(input logic [31:0] a, input logic [31:0] b,
                                        input logic rem);
      if (b == 32'd0) return rem ? a : 32'hFFFF_FFFF;
      return rem ? (a % b) : (a / b);
   endfunction

   always @(posedge clk) begin
      if (model_clr) begin
         for (int i = 0; i < LATENCY; i++) begin
            pv[i] <= 1'b0;
            pa[i] <= 32'd0;
         end
      end else if (!stall) begin
         for (int i = LATENCY - 1; i > 0; i--) begin
            pv[i] <= pv[i-1];
            pa[i] <= pa[i-1];
         end
         pv[0] <= div_in_valid;
         pa[0] <= udiv(div_dividend, div_divisor, div_ctrl[1]);
      end
   end

   assign div_out_valid = pv[LATENCY-1];
   assign div_ans       = pa[LATENCY-1];

   // Result monitor: one record per result consumed (res_valid while not stalled).
   always @(negedge clk) begin
      if (!rst && !stall && res_valid) begin
         mon_d.push_back(res_data);
         mon_t.push_back(res_tag);
         mon_c.push_back(cyc);
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_mon();
      mon_d.delete();
      mon_t.delete();
      mon_c.delete();
      acc_c.delete();
   endtask

   task automatic send_op(input logic [1:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] t);
      int k;
      op_valid = 1'b1;
      op_func  = f;
      op_a     = a;
      op_b     = b;
      op_tag   = t;
      k = 0;
      while (!op_ready && k < 50) begin
         step();
         k++;
      end
      step();
      acc_c.push_back(cyc);
      op_valid = 1'b0;
   endtask

   task automatic wait_results(input int n, input int budget);
      int k;
      k = 0;
      while (mon_d.size() < n && k < budget) begin
         step();
         k++;
      end
      n_checks++;
      if (mon_d.size() < n) begin
         n_errors++;
         $display("FAIL wait_results: got %0d results, required %0d", mon_d.size(), n);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; stall = 1'b0; op_valid = 1'b0; op_func = 2'b00;
      op_a = '0; op_b = '0; op_tag = '0; model_clr = 1'b1;
      step(); step();
      model_clr = 1'b0;
      n_checks++; if (res_valid !== 1'b0) begin n_errors++; $display("FAIL rst_res_valid: got %b want 0", res_valid); end
      n_checks++; if (res_data !== 32'd0) begin n_errors++; $display("FAIL rst_res_data: got %h want 0", res_data); end
      n_checks++; if (res_tag !== 5'd0) begin n_errors++; $display("FAIL rst_res_tag: got %h want 0", res_tag); end
      n_checks++; if (div_in_valid !== 1'b0) begin n_errors++; $display("FAIL rst_div_in_valid: got %b want 0", div_in_valid); end
      n_checks++; if (div_dividend !== 32'd0 || div_divisor !== 32'd0 || div_ctrl !== 2'd0) begin
         n_errors++; $display("FAIL rst_div_bus: got %h %h %b want zeros", div_dividend, div_divisor, div_ctrl); end
      n_checks++; if (op_ready !== 1'b1) begin n_errors++; $display("FAIL rst_op_ready: got %b want 1", op_ready); end
      stall = 1'b1; #1;
      n_checks++; if (op_ready !== 1'b0) begin n_errors++; $display("FAIL rst_op_ready_stall: got %b want 0", op_ready); end
      stall = 1'b0;
      step();
      rst = 1'b0;
      step();
   endtask

   task automatic test_signed();
      logic [31:0] ed [2];
      logic [4:0]  et [2];
      ed = '{32'hFFFF_FFFD, 32'hFFFF_FFFF};
      et = '{5'd3, 5'd4};
      clear_mon();
      send_op(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd3);
      n_checks++; if (div_in_valid !== 1'b1 || div_dividend !== 32'd7 || div_divisor !== 32'd2 || div_ctrl !== 2'b00) begin
         n_errors++; $display("FAIL issue_div: got v=%b %h %h %b want 1 7 2 00", div_in_valid, div_dividend, div_divisor, div_ctrl); end
      send_op(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd4);
      n_checks++; if (div_in_valid !== 1'b1 || div_dividend !== 32'd7 || div_ctrl !== 2'b10) begin
         n_errors++; $display("FAIL issue_rem: got v=%b %h %b want 1 7 10", div_in_valid, div_dividend, div_ctrl); end
      step();
      n_checks++; if (div_in_valid !== 1'b0) begin n_errors++; $display("FAIL issue_idle: got %b want 0", div_in_valid); end
      wait_results(2, 80);
      for (int i = 0; i < 2; i++) begin
         if (i < mon_d.size()) begin
            n_checks++; if (mon_d[i] !== ed[i]) begin n_errors++; $display("FAIL signed_data[%0d]: got %h want %h", i, mon_d[i], ed[i]); end
            n_checks++; if (mon_t[i] !== et[i]) begin n_errors++; $display("FAIL signed_tag[%0d]: got %0d want %0d", i, mon_t[i], et[i]); end
            n_checks++; if (mon_c[i] - acc_c[i] != RES_LAT) begin
               n_errors++; $display("FAIL signed_latency[%0d]: got %0d want %0d", i, mon_c[i] - acc_c[i], RES_LAT); end
         end
      end
   endtask

   task automatic test_special();
      logic [1:0]  vf [8];
      logic [31:0] va [8];
      logic [31:0] vb [8];
      logic [31:0] ed [8];
      vf = '{2'b01, 2'b11, 2'b00, 2'b00, 2'b10, 2'b10, 2'b00, 2'b10};
      va = '{32'hFFFF_FFFF, 32'd7, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFF8, 32'd7};
      vb = '{32'd1, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFE, 32'hFFFF_FFFE};
      ed = '{32'hFFFF_FFFF, 32'd7, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 32'h8000_0000, 32'd4, 32'd1};
      clear_mon();
      for (int i = 0; i < 8; i++) send_op(vf[i], va[i], vb[i], 5'(i + 5));
      wait_results(8, 100);
      for (int i = 0; i < 8; i++) begin
         if (i < mon_d.size()) begin
            n_checks++; if (mon_d[i] !== ed[i]) begin n_errors++; $display("FAIL special_data[%0d]: got %h want %h", i, mon_d[i], ed[i]); end
            n_checks++; if (mon_t[i] !== 5'(i + 5)) begin n_errors++; $display("FAIL special_tag[%0d]: got %0d want %0d", i, mon_t[i], i + 5); end
         end
      end
   endtask

   task automatic test_back_to_back();
      clear_mon();
      for (int i = 0; i < 32; i++) begin
         n_checks++; if (op_ready !== 1'b1) begin n_errors++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, op_ready); end
         if (i % 2 == 0) send_op(2'b01, 32'(100 * i + 7), 32'd10, 5'(i));
         else            send_op(2'b11, 32'(100 * i + 7), 32'd10, 5'(i));
      end
      n_checks++; if (acc_c[31] - acc_c[0] != 31) begin n_errors++; $display("FAIL b2b_accept_span: got %0d want 31", acc_c[31] - acc_c[0]); end
      wait_results(32, 120);
      for (int i = 0; i < 32; i++) begin
         if (i < mon_d.size()) begin
            n_checks++;
            if (mon_d[i] !== ((i % 2 == 0) ? 32'(10 * i) : 32'd7) || mon_t[i] !== 5'(i) || mon_c[i] != mon_c[0] + i) begin
               n_errors++; $display("FAIL b2b_result[%0d]: got %h tag %0d cyc+%0d want %h tag %0d cyc+%0d", i, mon_d[i], mon_t[i],
                                    mon_c[i] - mon_c[0], (i % 2 == 0) ? 32'(10 * i) : 32'd7, i, i);
            end
         end
      end
      n_checks++; if (mon_c.size() > 0 && mon_c[0] - acc_c[0] != RES_LAT) begin
         n_errors++; $display("FAIL b2b_latency: got %0d want %0d", mon_c[0] - acc_c[0], RES_LAT); end
      step(); step();
      n_checks++; if (dut.r_count !== '0) begin n_errors++; $display("FAIL b2b_count: got %0d want 0", dut.r_count); end
   endtask

   task automatic test_full_stall();
      clear_mon();
      for (int i = 0; i < 29; i++) send_op(2'b00, 32'(0 - 6 * i), 32'd3, 5'(i));
      stall = 1'b1;
      op_valid = 1'b1; op_func = 2'b01; op_a = 32'd99; op_b = 32'd9; op_tag = 5'd31;
      #1;
      for (int i = 0; i < 10; i++) begin
         n_checks++; if (op_ready !== 1'b0) begin n_errors++; $display("FAIL full_ready[%0d]: got %b want 0", i, op_ready); end
         step();
      end
      n_checks++; if (dut.r_count !== 5'd29) begin n_errors++; $display("FAIL full_count: got %0d want 29", dut.r_count); end
      op_valid = 1'b0;
      stall = 1'b0;
      wait_results(29, 100);
      step(); step(); step();
      n_checks++; if (mon_d.size() != 29) begin n_errors++; $display("FAIL full_result_count: got %0d want 29", mon_d.size()); end
      for (int i = 0; i < 29; i++) begin
         if (i < mon_d.size()) begin
            n_checks++;
            if (mon_d[i] !== 32'(0 - 2 * i) || mon_t[i] !== 5'(i) || mon_c[i] != mon_c[0] + i) begin
               n_errors++; $display("FAIL full_result[%0d]: got %h tag %0d cyc+%0d want %h tag %0d cyc+%0d", i, mon_d[i], mon_t[i],
                                    mon_c[i] - mon_c[0], 32'(0 - 2 * i), i, i);
            end
         end
      end
      n_checks++; if (mon_c.size() > 0 && mon_c[0] - acc_c[0] != RES_LAT + 10) begin
         n_errors++; $display("FAIL full_latency: got %0d want %0d", mon_c[0] - acc_c[0], RES_LAT + 10); end
   endtask

   task automatic test_stall_midflight();
      int k;
      clear_mon();
      send_op(2'b01, 32'd100, 32'd7, 5'd17);
      for (int i = 0; i < 10; i++) step();
      stall = 1'b1;
      for (int i = 0; i < 5; i++) step();
      stall = 1'b0;
      wait_results(1, 60);
      if (mon_d.size() > 0) begin
         n_checks++; if (mon_d[0] !== 32'd14 || mon_t[0] !== 5'd17) begin
            n_errors++; $display("FAIL midstall_data: got %h tag %0d want 0000000e tag 17", mon_d[0], mon_t[0]); end
         n_checks++; if (mon_c[0] - acc_c[0] != RES_LAT + 5) begin
            n_errors++; $display("FAIL midstall_latency: got %0d want %0d", mon_c[0] - acc_c[0], RES_LAT + 5); end
      end
      send_op(2'b11, 32'd100, 32'd7, 5'd18);
      k = 0;
      while (res_valid !== 1'b1 && k < 60) begin step(); k++; end
      stall = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         n_checks++; if (res_valid !== 1'b1 || res_data !== 32'd2 || res_tag !== 5'd18) begin
            n_errors++; $display("FAIL hold_res[%0d]: got v=%b %h tag %0d want 1 00000002 tag 18", i, res_valid, res_data, res_tag); end
      end
      stall = 1'b0;
      step();
      n_checks++; if (res_valid !== 1'b0) begin n_errors++; $display("FAIL hold_release: got %b want 0", res_valid); end
      step(); step();
      n_checks++; if (mon_d.size() != 2) begin n_errors++; $display("FAIL hold_dup: got %0d results want 2", mon_d.size()); end
   endtask

   task automatic test_reset_midflight();
      clear_mon();
      send_op(2'b01, 32'd50, 32'd5, 5'd19);
      send_op(2'b01, 32'd60, 32'd5, 5'd20);
      send_op(2'b01, 32'd70, 32'd5, 5'd21);
      for (int i = 0; i < 10; i++) step();
      #2 rst = 1'b1;
      #1;
      n_checks++; if (res_valid !== 1'b0 || res_data !== 32'd0 || res_tag !== 5'd0) begin
         n_errors++; $display("FAIL midrst_res: got v=%b %h tag %0d want zeros", res_valid, res_data, res_tag); end
      n_checks++; if (div_dividend !== 32'd0 || div_divisor !== 32'd0 || div_ctrl !== 2'd0 || div_in_valid !== 1'b0) begin
         n_errors++; $display("FAIL midrst_div: got %h %h %b %b want zeros", div_dividend, div_divisor, div_ctrl, div_in_valid); end
      n_checks++; if (dut.r_count !== '0) begin n_errors++; $display("FAIL midrst_count: got %0d want 0", dut.r_count); end
      step(); step();
      rst = 1'b0;
      for (int i = 0; i < 50; i++) step();
      n_checks++; if (mon_d.size() != 0) begin n_errors++; $display("FAIL midrst_stale: got %0d results want 0", mon_d.size()); end
      clear_mon();
      send_op(2'b00, 32'd100, 32'hFFFF_FFF9, 5'd22);
      wait_results(1, 60);
      if (mon_d.size() > 0) begin
         n_checks++; if (mon_d[0] !== 32'hFFFF_FFF2 || mon_t[0] !== 5'd22 || mon_c[0] - acc_c[0] != RES_LAT) begin
            n_errors++; $display("FAIL postrst_op: got %h tag %0d lat %0d want fffffff2 tag 22 lat %0d",
                                 mon_d[0], mon_t[0], mon_c[0] - acc_c[0], RES_LAT); end
      end
   endtask

   initial begin
      test_reset();
      test_signed();
      test_special();
      test_back_to_back();
      test_full_stall();
      test_stall_midflight();
      test_reset_midflight();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
